mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port system RAM between the CPU memory port and a DMA/loader port. It sits between the CPU's memory-side strobes and the RAM. It serialises accesses with a fixed three-cycle access sequence, round-robin or CPU-priority selection, and a bounded lock for burst transfers.

## Interface
Parameters:
- ADDR_W, 8, address width
- DATA_W, 8, data width
- LOCK_MAX, 16, maximum consecutive locked grants while the other port is requesting (range 1..255)
- CPU_PRIORITY, 0, arbitration policy: 0 = round-robin, 1 = port 0 always wins unlocked arbitration

Ports (x = 0 for the CPU port, x = 1 for the DMA port):
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset; the block is in reset while reset = 0
- req_x  in  1  access request, level
- we_x  in  1  1 = write, 0 = read; sampled with req_x
- lock_x  in  1  keep ownership after this access if req_x stays high
- addr_x  in  ADDR_W  access address
- wdata_x  in  DATA_W  write data
- gnt_x  out  1  port x owns the RAM (ACCESS through DONE)
- done_x  out  1  one-cycle completion pulse
- rdata_x  out  DATA_W  read data of last completed read for port x
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after ram_en
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCESS, WAIT, DONE. Every output comes from a register or from a decode of the state register. There are no combinational paths from inputs to outputs.
- Arbitration happens at a clock edge in IDLE or DONE.
  - Locked owner: if the owner's lock_x and req_x are both 1 and lock_cnt < LOCK_MAX, the owner wins.
  - Otherwise, with CPU_PRIORITY = 1, port 0 wins if req_0 = 1.
  - Otherwise, round-robin: the port that is not last_owner wins if it is requesting. Otherwise the only requester wins.
  - If there is no requester, the next state is IDLE.
- When a port wins:
  - The block latches that port's we/addr/wdata into the access registers.
  - owner and last_owner take the winner, and the next state is ACCESS.
  - lock_cnt increments if the owner won again via lock. Otherwise lock_cnt resets to 1.
- ACCESS: ram_en = 1, and ram_we/ram_addr/ram_wdata are driven from the latched registers. Next state is WAIT.
- WAIT: ram_en = 0. On a read, the block captures ram_rdata into rdata_owner at the end of WAIT. Next state is DONE.
- DONE: done_owner = 1 for exactly this cycle. Arbitration as above selects ACCESS or IDLE.
- gnt_owner = 1 in ACCESS, WAIT and DONE. The other port's gnt is 0 in these states.
- Writes leave rdata_x unchanged. rdata_x holds its value until that port's next completed read.
- The lock limit is LOCK_MAX. When lock_cnt reaches LOCK_MAX and the other port is requesting, the owner loses the next arbitration. If the other port is idle, the lock continues and lock_cnt saturates at LOCK_MAX.
- If a requester drops req_x after being granted, the latched access still completes and done_x still pulses.
- A requester that wants back-to-back accesses keeps req_x high and presents the next addr/we/wdata by the DONE cycle.

## Timing
- When reset = 0 (asynchronous), the block immediately enters IDLE and drives:
  - gnt_x = 0, done_x = 0, rdata_x = 0
  - ram_en = 0, ram_we = 0, ram_addr = 0, ram_wdata = 0
  - busy = 0, last_owner = 1 (so that port 0 wins first), lock_cnt = 0
- An in-flight access aborted by reset produces no done pulse. The RAM sees at most the single ACCESS cycle already issued.
- Latency for a request sampled high at edge E0 in IDLE:
  - ACCESS in the cycle after E0
  - WAIT in the cycle after E1
  - DONE (done_x = 1, read data valid on rdata_x) in the cycle after E2
- Throughput is one access per 3 cycles under continuous requests (DONE → ACCESS).
- If both ports request simultaneously in IDLE after reset, port 0 wins and port 1 is served next.
- ram_en is never asserted in two consecutive cycles.

## Test plan
- Read: preload RAM[0x20] = 0xA5, hold req_0 = 1, we_0 = 0, addr_0 = 0x20 → ram_en pulses 1 cycle after sampling, done_0 pulses 3 cycles after sampling, and rdata_0 = 0xA5.
- Write then read: port 1 writes 0x3C to 0x80, then port 1 reads 0x80 → rdata_1 = 0x3C. rdata_0 is unchanged.
- Contention: req_0 and req_1 held high continuously with CPU_PRIORITY = 0 → grants alternate 0, 1, 0, 1. A done pulse occurs every 3 cycles, and gnt_0 and gnt_1 are never both 1.
- Lock: LOCK_MAX = 4, port 1 holds lock_1 = 1 and req_1 = 1 while req_0 = 1 → port 1 completes 4 accesses, then port 0 is granted. With req_0 = 0, port 1 continues past 4 accesses.
- Priority: CPU_PRIORITY = 1, both ports requesting, no lock → port 0 wins every arbitration. Port 1 is granted only when req_0 = 0.
- Reset mid-access: assert reset = 0 during WAIT → all outputs are 0 immediately and no done pulse occurs. After release, a pending req_1 is served with normal 3-cycle latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing a single-port RAM between the CPU (port 0) and DMA (port 1).
// Fixed ACCESS/WAIT/DONE sequence with round-robin or CPU-priority selection and bounded lock.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LOCK_MAX     = 16,
  parameter int unsigned CPU_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              we_0,
  input  logic              lock_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic              lock_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              done_0,
  output logic              done_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);
  localparam bit PRIO = (CPU_PRIORITY != 0);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic                acc_we_q, acc_we_d;
  logic [ADDR_W-1:0]   acc_addr_q, acc_addr_d;
  logic [DATA_W-1:0]   acc_wdata_q, acc_wdata_d;

  logic win, win_port, win_lock;
  logic req_own, req_oth, lock_own;

  // owner_q doubles as last_owner: both always take the same winner
  assign req_own  = owner_q ? req_1  : req_0;
  assign req_oth  = owner_q ? req_0  : req_1;
  assign lock_own = owner_q ? lock_1 : lock_0;

  assign ram_addr  = acc_addr_q;
  assign ram_wdata = acc_wdata_q;

  // Next-state, arbitration and access-register latch
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lock_cnt_d  = lock_cnt_q;
    acc_we_d    = acc_we_q;
    acc_addr_d  = acc_addr_q;
    acc_wdata_d = acc_wdata_q;
    win         = 1'b0;
    win_port    = 1'b0;
    win_lock    = 1'b0;

    case (state_q)
      S_ACCESS: state_d = S_WAIT;
      S_WAIT:   state_d = S_DONE;
      default: begin
        // Lock only extends a continuous ownership, i.e. straight out of DONE
        if (state_q == S_DONE && req_own && lock_own &&
            (lock_cnt_q < LOCK_LIM || !req_oth)) begin
          win      = 1'b1;
          win_port = owner_q;
          win_lock = 1'b1;
        end else if (PRIO && req_0) begin
          win      = 1'b1;
          win_port = 1'b0;
        end else if (req_oth) begin
          win      = 1'b1;
          win_port = ~owner_q;
        end else if (req_own) begin
          win      = 1'b1;
          win_port = owner_q;
        end

        if (win) begin
          state_d     = S_ACCESS;
          owner_d     = win_port;
          acc_we_d    = win_port ? we_1    : we_0;
          acc_addr_d  = win_port ? addr_1  : addr_0;
          acc_wdata_d = win_port ? wdata_1 : wdata_0;
          if (win_lock) begin
            lock_cnt_d = (lock_cnt_q < LOCK_LIM) ? lock_cnt_q + CNT_W'(1) : lock_cnt_q;
          end else begin
            lock_cnt_d = CNT_W'(1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b1;
      lock_cnt_q  <= '0;
      acc_we_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      gnt_0       <= 1'b0;
      gnt_1       <= 1'b0;
      done_0      <= 1'b0;
      done_1      <= 1'b0;
      rdata_0     <= '0;
      rdata_1     <= '0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lock_cnt_q  <= lock_cnt_d;
      acc_we_q    <= acc_we_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      gnt_0       <= (state_d != S_IDLE) && !owner_d;
      gnt_1       <= (state_d != S_IDLE) &&  owner_d;
      done_0      <= (state_d == S_DONE) && !owner_d;
      done_1      <= (state_d == S_DONE) &&  owner_d;
      ram_en      <= (state_d == S_ACCESS);
      ram_we      <= (state_d == S_ACCESS) && acc_we_d;
      busy        <= (state_d != S_IDLE);
      // RAM read data is valid during WAIT; capture it for the owner
      if (state_q == S_WAIT && !acc_we_q) begin
        if (owner_q) rdata_1 <= ram_rdata;
        else         rdata_0 <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin/lock instance plus a CPU-priority instance.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req_0, we_0, lock_0, req_1, we_1, lock_1;
  logic [7:0] addr_0, wdata_0, addr_1, wdata_1;

  logic       gnt_0, gnt_1, done_0, done_1, ram_en, ram_we, busy;
  logic [7:0] rdata_0, rdata_1, ram_addr, ram_wdata, ram_rdata;

  logic       p_gnt_0, p_gnt_1, p_done_0, p_done_1, p_ram_en, p_ram_we, p_busy;
  logic [7:0] p_rdata_0, p_rdata_1, p_ram_addr, p_ram_wdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4), .CPU_PRIORITY(0)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .we_0(we_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .req_1(req_1), .we_1(we_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(16), .CPU_PRIORITY(1)) dut_p (
    .clk(clk), .reset(reset),
    .req_0(req_0), .we_0(we_0), .lock_0(lock_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .req_1(req_1), .we_1(we_1), .lock_1(lock_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_0(p_gnt_0), .gnt_1(p_gnt_1), .done_0(p_done_0), .done_1(p_done_1),
    .rdata_0(p_rdata_0), .rdata_1(p_rdata_1),
    .ram_en(p_ram_en), .ram_we(p_ram_we), .ram_addr(p_ram_addr), .ram_wdata(p_ram_wdata),
    .ram_rdata(8'h00), .busy(p_busy)
  );

  // Synchronous single-port RAM with one-cycle read latency and a bench preload port
  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;
  always_ff @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en) ram_rdata <= mem[ram_addr];
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((busy || p_busy) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || p_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle busy=%b p_busy=%b expected 0 0", name, busy, p_busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({gnt_0, gnt_1, done_0, done_1, ram_en, ram_we, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b expected 0000000", {gnt_0, gnt_1, done_0, done_1, ram_en, ram_we, busy});
    end
    checks++;
    if ({rdata_0, rdata_1, ram_addr, ram_wdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h expected 0", {rdata_0, rdata_1, ram_addr, ram_wdata});
    end
    checks++;
    if ({p_gnt_0, p_gnt_1, p_done_0, p_done_1, p_ram_en, p_ram_we, p_busy, p_rdata_0, p_rdata_1,
         p_ram_addr, p_ram_wdata} !== 39'h0) begin
      errors++;
      $display("FAIL reset_prio got %h expected 0", {p_gnt_0, p_gnt_1, p_done_0, p_done_1, p_ram_en,
               p_ram_we, p_busy, p_rdata_0, p_rdata_1, p_ram_addr, p_ram_wdata});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b expected 0", busy);
    end
  endtask

  task automatic test_read;
    preload(8'h20, 8'hA5);
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 8'h20;
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, gnt_0, gnt_1, busy, done_0} !== 6'b101010 || ram_addr !== 8'h20) begin
      errors++;
      $display("FAIL read_access en/we/g0/g1/busy/done=%b addr=%h expected 101010 20",
               {ram_en, ram_we, gnt_0, gnt_1, busy, done_0}, ram_addr);
    end
    req_0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_en, gnt_0, done_0} !== 3'b010) begin
      errors++;
      $display("FAIL read_wait en/g0/done=%b expected 010", {ram_en, gnt_0, done_0});
    end
    @(negedge clk);
    checks++;
    if (done_0 !== 1'b1 || rdata_0 !== 8'hA5 || done_1 !== 1'b0) begin
      errors++;
      $display("FAIL read_done done0=%b done1=%b rdata0=%h expected 1 0 a5", done_0, done_1, rdata_0);
    end
    @(negedge clk);
    checks++;
    if ({done_0, busy, gnt_0} !== 3'b000) begin
      errors++;
      $display("FAIL read_idle done/busy/g0=%b expected 000", {done_0, busy, gnt_0});
    end
  endtask

  task automatic test_write_read;
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 8'h80; wdata_1 = 8'h3C;
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, gnt_1, gnt_0} !== 4'b1110 || ram_addr !== 8'h80 || ram_wdata !== 8'h3C) begin
      errors++;
      $display("FAIL wr_access en/we/g1/g0=%b addr=%h wdata=%h expected 1110 80 3c",
               {ram_en, ram_we, gnt_1, gnt_0}, ram_addr, ram_wdata);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done_1 !== 1'b1 || rdata_1 !== 8'h00) begin
      errors++;
      $display("FAIL wr_done done1=%b rdata1=%h expected 1 00", done_1, rdata_1);
    end
    we_1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, gnt_1} !== 3'b101 || mem[8'h80] !== 8'h3C) begin
      errors++;
      $display("FAIL rd_back_to_back en/we/g1=%b mem80=%h expected 101 3c", {ram_en, ram_we, gnt_1}, mem[8'h80]);
    end
    req_1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done_1 !== 1'b1 || rdata_1 !== 8'h3C || rdata_0 !== 8'hA5) begin
      errors++;
      $display("FAIL rd_done done1=%b rdata1=%h rdata0=%h expected 1 3c a5", done_1, rdata_1, rdata_0);
    end
    wait_idle("write_read");
  endtask

  task automatic test_contention;
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 8'h20;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 8'h80;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (gnt_0 && gnt_1) begin
        errors++;
        $display("FAIL cont_both_gnt cycle %0d g0=%b g1=%b expected not both", k, gnt_0, gnt_1);
      end
      checks++;
      if ((done_0 | done_1) !== (k % 3 == 0)) begin
        errors++;
        $display("FAIL cont_done cycle %0d got %b expected %b", k, done_0 | done_1, k % 3 == 0);
      end
      checks++;
      if (ram_en !== (k % 3 == 1)) begin
        errors++;
        $display("FAIL cont_ram_en cycle %0d got %b expected %b", k, ram_en, k % 3 == 1);
      end
      if (k % 3 == 1) begin
        checks++;
        if (gnt_0 !== ((k / 3) % 2 == 0)) begin
          errors++;
          $display("FAIL cont_order cycle %0d gnt0=%b expected %b", k, gnt_0, (k / 3) % 2 == 0);
        end
      end
    end
    req_0 = 1'b0; req_1 = 1'b0;
    wait_idle("contention");
  endtask

  task automatic test_lock;
    req_1 = 1'b1; lock_1 = 1'b1; we_1 = 1'b0; addr_1 = 8'h80; req_0 = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k % 3 == 1) begin
        checks++;
        if (ram_en !== 1'b1 || gnt_1 !== (k < 13) || gnt_0 !== (k == 13)) begin
          errors++;
          $display("FAIL lock_limit cycle %0d en=%b g0=%b g1=%b expected 1 %b %b",
                   k, ram_en, gnt_0, gnt_1, k == 13, k < 13);
        end
      end
      if (k == 1) req_0 = 1'b1;
    end
    req_0 = 1'b0; req_1 = 1'b0; lock_1 = 1'b0;
    wait_idle("lock_limit");

    req_1 = 1'b1; lock_1 = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k % 3 == 1) begin
        checks++;
        if (ram_en !== 1'b1 || gnt_1 !== (k < 19) || gnt_0 !== (k == 19)) begin
          errors++;
          $display("FAIL lock_sat cycle %0d en=%b g0=%b g1=%b expected 1 %b %b",
                   k, ram_en, gnt_0, gnt_1, k == 19, k < 19);
        end
      end
      if (k == 16) req_0 = 1'b1;
    end
    req_0 = 1'b0; req_1 = 1'b0; lock_1 = 1'b0;
    wait_idle("lock_sat");
  endtask

  task automatic test_priority;
    req_0 = 1'b1; req_1 = 1'b1; we_0 = 1'b0; we_1 = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k % 3 == 1) begin
        checks++;
        if (p_ram_en !== 1'b1 || p_gnt_0 !== (k < 13) || p_gnt_1 !== (k == 13)) begin
          errors++;
          $display("FAIL prio cycle %0d en=%b g0=%b g1=%b expected 1 %b %b",
                   k, p_ram_en, p_gnt_0, p_gnt_1, k < 13, k == 13);
        end
      end
      if (k == 12) req_0 = 1'b0;
    end
    req_1 = 1'b0;
    wait_idle("priority");
  endtask

  task automatic test_reset_mid;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 8'h80; lock_1 = 1'b0; req_0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ram_en, gnt_1, busy} !== 3'b011) begin
      errors++;
      $display("FAIL rstmid_wait en/g1/busy=%b expected 011", {ram_en, gnt_1, busy});
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({gnt_0, gnt_1, done_0, done_1, ram_en, ram_we, busy} !== 7'b0 ||
        {rdata_0, rdata_1, ram_addr, ram_wdata} !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs ctl=%b data=%h expected 0 0",
               {gnt_0, gnt_1, done_0, done_1, ram_en, ram_we, busy}, {rdata_0, rdata_1, ram_addr, ram_wdata});
    end
    @(negedge clk);
    checks++;
    if ({done_1, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_nodone done1/busy=%b expected 00", {done_1, busy});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_en, gnt_1, done_1} !== 3'b110 || rdata_1 !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_access en/g1/done=%b rdata1=%h expected 110 00", {ram_en, gnt_1, done_1}, rdata_1);
    end
    req_1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_en, done_1} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_wait2 en/done=%b expected 00", {ram_en, done_1});
    end
    @(negedge clk);
    checks++;
    if (done_1 !== 1'b1 || rdata_1 !== 8'h3C) begin
      errors++;
      $display("FAIL rstmid_done done1=%b rdata1=%h expected 1 3c", done_1, rdata_1);
    end
    wait_idle("reset_mid");
  endtask

  initial begin
    reset = 1'b1;
    req_0 = 1'b0; we_0 = 1'b0; lock_0 = 1'b0; addr_0 = 8'h00; wdata_0 = 8'h00;
    req_1 = 1'b0; we_1 = 1'b0; lock_1 = 1'b0; addr_1 = 8'h00; wdata_1 = 8'h00;
    pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
    test_reset;
    test_read;
    test_write_read;
    test_contention;
    test_lock;
    test_priority;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
